// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// A shift-add multiplier and a restoring divider share one datapath and
// produce one bit per cycle over DATA_WIDTH cycles.
// Divide-by-zero and signed overflow skip the iterations and finish on the
// cycle after the start is accepted.
//
// Ports:
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   Start          operation request, sampled only in IDLE
//   Flush          synchronous abort from any state (wins over Start)
//   Funct3         RV32M operation select
//   SrcA, SrcB     rs1 / rs2 operands
//   Busy           high while iterating or fixing up the result (registered)
//   Done           one-cycle completion pulse (registered)
//   MulDivResult   result, held until the next completion
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FUNCT_LENGTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    Start,
  input  logic                    Flush,
  input  logic [FUNCT_LENGTH-1:0] Funct3,
  input  logic [DATA_WIDTH-1:0]   SrcA,
  input  logic [DATA_WIDTH-1:0]   SrcB,
  output logic                    Busy,
  output logic                    Done,
  output logic [DATA_WIDTH-1:0]   MulDivResult
);

  localparam int unsigned CNT_W  = 6;
  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t                  state_q, state_d;
  logic [FUNCT_LENGTH-1:0] op_q;
  logic                    neg_q;
  logic [DATA_WIDTH-1:0]   a_q;     // multiplier (shifts right) / dividend->quotient (shifts left)
  logic [DATA_WIDTH-1:0]   b_q;     // multiplicand / divisor magnitude
  logic [DATA_WIDTH-1:0]   part_q;  // product high half / partial remainder
  logic [CNT_W-1:0]        cnt_q;
  logic                    busy_q, done_q;
  logic [DATA_WIDTH-1:0]   result_q;

  logic                    accept_c, load_fix_c;
  logic                    is_div_c, sign_a_en_c, sign_b_en_c, sa_c, sb_c, neg_c;
  logic [DATA_WIDTH-1:0]   mag_a_c, mag_b_c;
  logic                    div_zero_c, ovf_c, special_c;
  logic [DATA_WIDTH-1:0]   special_res_c;
  logic [DATA_WIDTH:0]     mul_sum_c, div_shift_c;
  logic                    div_ge_c;
  logic [DATA_WIDTH-1:0]   div_rem_c;
  logic [PROD_W-1:0]       raw_c, fixed_c;
  logic [DATA_WIDTH-1:0]   fix_res_c;

  // Operand decode, sign handling and special-case detection on the request
  always_comb begin
    is_div_c    = Funct3[2];
    sign_a_en_c = is_div_c ? ~Funct3[0] : (Funct3[1:0] != 2'b11);
    sign_b_en_c = is_div_c ? ~Funct3[0] : ~Funct3[1];
    sa_c        = sign_a_en_c & SrcA[DATA_WIDTH-1];
    sb_c        = sign_b_en_c & SrcB[DATA_WIDTH-1];
    mag_a_c     = sa_c ? -SrcA : SrcA;
    mag_b_c     = sb_c ? -SrcB : SrcB;
    // Remainder takes the dividend's sign; everything else the XOR
    neg_c       = (is_div_c & Funct3[1]) ? sa_c : (sa_c ^ sb_c);
    div_zero_c  = is_div_c & (SrcB == '0);
    ovf_c       = is_div_c & ~Funct3[0] & (SrcA == MIN_NEG) & (SrcB == '1);
    special_c   = div_zero_c | ovf_c;
    special_res_c = '0;
    if (div_zero_c) begin
      special_res_c = Funct3[1] ? SrcA : '1;
    end else if (ovf_c) begin
      special_res_c = Funct3[1] ? '0 : MIN_NEG;
    end
  end

  // One iteration step for each of multiply and divide
  always_comb begin
    mul_sum_c   = {1'b0, part_q} + (a_q[0] ? {1'b0, b_q} : '0);
    div_shift_c = {part_q, a_q[DATA_WIDTH-1]};
    div_ge_c    = (div_shift_c >= {1'b0, b_q});
    // When the subtract succeeds the true difference is below b_q, so it fits
    div_rem_c   = div_ge_c ? (div_shift_c[DATA_WIDTH-1:0] - b_q) : div_shift_c[DATA_WIDTH-1:0];
  end

  // Sign fix-up and output selection; one negator serves every operation
  always_comb begin
    raw_c     = op_q[2] ? {{DATA_WIDTH{1'b0}}, (op_q[1] ? part_q : a_q)} : {part_q, a_q};
    fixed_c   = neg_q ? -raw_c : raw_c;
    fix_res_c = (op_q[2] | (op_q[1:0] == 2'b00)) ? fixed_c[DATA_WIDTH-1:0]
                                                 : fixed_c[PROD_W-1:DATA_WIDTH];
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    load_fix_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start & ~Flush) begin
          accept_c = 1'b1;
          state_d  = special_c ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX: begin
        load_fix_c = ~Flush;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Flush) state_d = IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Datapath, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      part_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      if (accept_c) begin
        op_q   <= Funct3;
        neg_q  <= neg_c;
        a_q    <= mag_a_c;
        b_q    <= mag_b_c;
        part_q <= '0;
        cnt_q  <= '0;
      end else if (state_q == CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
        if (op_q[2]) begin
          part_q <= div_rem_c;
          a_q    <= {a_q[DATA_WIDTH-2:0], div_ge_c};
        end else begin
          part_q <= mul_sum_c[DATA_WIDTH:1];
          a_q    <= {mul_sum_c[0], a_q[DATA_WIDTH-1:1]};
        end
      end
      if (accept_c & special_c) result_q <= special_res_c;
      else if (load_fix_c)      result_q <= fix_res_c;
      busy_q <= (state_d == CALC) | (state_d == FIX);
      done_q <= (state_d == DONE);
    end
  end

  assign Busy         = busy_q;
  assign Done         = done_q;
  assign MulDivResult = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected result,
// completion cycle and busy length per accepted op; the monitor pops on Done.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n, Start, Flush;
  logic [2:0]  Funct3;
  logic [31:0] SrcA, SrcB;
  logic        Busy, Done;
  logic [31:0] MulDivResult;

  muldiv_unit dut (
    .clk(clk), .reset_n(reset_n), .Start(Start), .Flush(Flush),
    .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
    .Busy(Busy), .Done(Done), .MulDivResult(MulDivResult)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    int          done_cyc;
    int          busy;
    int          id;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          run = 0;
  int          next_id = 0;
  logic [31:0] last_exp = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares whenever the DUT signals completion
  always @(negedge clk) begin
    exp_t e;
    if (Busy === 1'b1) run++;
    if (Done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: Done at cycle %0d with no pending op, result %h", cyc, MulDivResult);
      end else begin
        e = sb.pop_front();
        check($sformatf("op%0d_result", e.id), MulDivResult, e.res);
        check($sformatf("op%0d_done_cycle", e.id), 32'(cyc), 32'(e.done_cyc));
        check($sformatf("op%0d_busy_cycles", e.id), 32'(run), 32'(e.busy));
      end
    end
    if (Busy !== 1'b1) run = 0;
  end

  function automatic void push(input logic [31:0] res, input int e0, input bit special);
    sb.push_back('{res: res, done_cyc: e0 + (special ? 0 : 33),
                   busy: (special ? 0 : 33), id: next_id});
    next_id++;
    last_exp = res;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout: %0d ops still pending", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit special);
    int e0;
    @(negedge clk);
    Funct3 = f; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    Start = 1'b0;
    push(exp, e0, special);
    wait_idle();
  endtask

  task automatic start_only(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            output int e0);
    @(negedge clk);
    Funct3 = f; SrcA = a; SrcB = b; Start = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    Start = 1'b0;
  endtask

  initial begin
    int e0;
    reset_n = 1'b0; Start = 1'b0; Flush = 1'b0;
    Funct3 = '0; SrcA = '0; SrcB = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_result", MulDivResult, 32'h0);
    reset_n = 1'b1;

    // Iterative operations
    issue(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0); // MUL 7*-3
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0); // MULH
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0); // MULHU
    issue(3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0); // MULHSU -1*2
    issue(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0); // DIV -7/2
    issue(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0); // REM -7/2
    issue(3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0); // DIV 7/-2
    issue(3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         1'b0); // REM 7/-2
    issue(3'b101, 32'd100,       32'd7,         32'd14,        1'b0); // DIVU
    issue(3'b111, 32'd100,       32'd7,         32'd2,         1'b0); // REMU
    issue(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1,         1'b0); // DIVU large divisor
    issue(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 1'b0); // REMU large divisor

    // Special cases
    issue(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1); // DIVU /0
    issue(3'b110, 32'd5,         32'd0,         32'd5,         1'b1); // REM /0
    issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1); // DIV overflow
    issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1); // REM overflow

    // Flush mid-calculation: back to idle, no Done, result kept
    issue(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    start_only(3'b100, 32'd1000, 32'd3, e0);
    while (cyc < e0 + 10) @(negedge clk);
    Flush = 1'b1;
    @(posedge clk); #1;
    Flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(Busy), 32'd0);
    check("flush_done", 32'(Done), 32'd0);
    check("flush_result", MulDivResult, last_exp);
    repeat (40) @(negedge clk);
    check("flush_result_later", MulDivResult, last_exp);

    // Flush wins over Start in the same cycle
    @(negedge clk);
    Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd3; Start = 1'b1; Flush = 1'b1;
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0;
    @(negedge clk);
    check("flush_prio_busy", 32'(Busy), 32'd0);
    check("flush_prio_done", 32'(Done), 32'd0);
    repeat (40) @(negedge clk);

    // Reset mid-calculation clears outputs immediately
    start_only(3'b100, 32'd1000, 32'd3, e0);
    while (cyc < e0 + 20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midreset_busy", 32'(Busy), 32'd0);
    check("midreset_done", 32'(Done), 32'd0);
    check("midreset_result", MulDivResult, 32'h0);
    last_exp = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_result", MulDivResult, 32'h0);
    issue(3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0); // MUL low half wraps to 0

    // Start held high; operands change mid-op and are sampled at each accept
    @(negedge clk);
    Funct3 = 3'b000; SrcA = 32'd3; SrcB = 32'd5; Start = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    push(32'd15, e0, 1'b0);
    repeat (5) @(negedge clk);
    Funct3 = 3'b101; SrcA = 32'd100; SrcB = 32'd7;
    push(32'd14, e0 + 35, 1'b0);
    while (cyc < e0 + 36) @(negedge clk);
    Funct3 = 3'b011; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
    push(32'hFFFF_FFFE, e0 + 70, 1'b0);
    while (cyc < e0 + 71) @(negedge clk);
    Start = 1'b0;
    wait_idle();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
